// File: rtl/branch_resolve_ctrl_if.sv
// Signal bundle between the ID-stage pipeline and the branch resolve sequencer.
// The master side drives the stage inputs; the slave side is the sequencer itself.
interface branch_resolve_ctrl_if;
    logic [2:0]  id_branch_op_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        ex_reg_write_i;
    logic        ex_mem_read_i;
    logic [4:0]  ex_rd_i;
    logic        mem_reg_write_i;
    logic        mem_mem_read_i;
    logic [4:0]  mem_rd_i;
    logic        ext_flush_i;
    logic        id_compare_i;

    logic [2:0]  compare_op_o;
    logic        forward_a_o;
    logic        forward_b_o;
    logic        pc_write_o;
    logic        if_id_write_o;
    logic        id_ex_bubble_o;
    logic        pc_src_o;
    logic        if_id_flush_o;
    logic [15:0] branch_count_o;
    logic [15:0] taken_count_o;
    logic [15:0] stall_count_o;

    modport master (
        output id_branch_op_i, id_rs_i, id_rt_i,
        output ex_reg_write_i, ex_mem_read_i, ex_rd_i,
        output mem_reg_write_i, mem_mem_read_i, mem_rd_i,
        output ext_flush_i, id_compare_i,
        input  compare_op_o, forward_a_o, forward_b_o,
        input  pc_write_o, if_id_write_o, id_ex_bubble_o,
        input  pc_src_o, if_id_flush_o,
        input  branch_count_o, taken_count_o, stall_count_o
    );

    modport slave (
        input  id_branch_op_i, id_rs_i, id_rt_i,
        input  ex_reg_write_i, ex_mem_read_i, ex_rd_i,
        input  mem_reg_write_i, mem_mem_read_i, mem_rd_i,
        input  ext_flush_i, id_compare_i,
        output compare_op_o, forward_a_o, forward_b_o,
        output pc_write_o, if_id_write_o, id_ex_bubble_o,
        output pc_src_o, if_id_flush_o,
        output branch_count_o, taken_count_o, stall_count_o
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: hazard stalls, MEM-to-ID forwarding select, comparator
// op gating, PC-select / IF/ID flush, and saturating branch statistics.
module branch_resolve_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_ctrl_if.slave  bus
);
    // RESOLVE covers the detect cycle of any hazard; STALL2 is the extra bubble an
    // EX-stage load needs before its data reaches the write-first register file.
    typedef enum logic {
        RESOLVE,
        STALL2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        is_branch;
    logic        uses_rt;
    logic        ex_hit;
    logic        mem_load_hit;
    logic [1:0]  stall_need;

    logic [2:0]  compare_op;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_bubble;
    logic        pc_src;
    logic        if_id_flush;
    logic        inc_branch;
    logic        inc_taken;
    logic        inc_stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        return (en && value != 16'hFFFF) ? value + 16'd1 : value;
    endfunction

    // A matching rd of zero can never hit, so a nonzero rd implies a nonzero source.
    always_comb begin
        is_branch    = bus.id_branch_op_i inside {[3'd1:3'd6]};
        uses_rt      = (bus.id_branch_op_i == 3'd2) || (bus.id_branch_op_i == 3'd3);
        ex_hit       = bus.ex_reg_write_i && (bus.ex_rd_i != 5'd0) &&
                       ((bus.ex_rd_i == bus.id_rs_i) ||
                        (uses_rt && (bus.ex_rd_i == bus.id_rt_i)));
        mem_load_hit = bus.mem_reg_write_i && bus.mem_mem_read_i && (bus.mem_rd_i != 5'd0) &&
                       ((bus.mem_rd_i == bus.id_rs_i) ||
                        (uses_rt && (bus.mem_rd_i == bus.id_rt_i)));
        stall_need   = 2'd0;
        if (ex_hit && bus.ex_mem_read_i) begin
            stall_need = 2'd2;
        end else if (ex_hit || mem_load_hit) begin
            stall_need = 2'd1;
        end
    end

    assign bus.forward_a_o = bus.mem_reg_write_i && !bus.mem_mem_read_i &&
                             (bus.mem_rd_i == bus.id_rs_i) && (bus.id_rs_i != 5'd0);
    assign bus.forward_b_o = uses_rt && bus.mem_reg_write_i && !bus.mem_mem_read_i &&
                             (bus.mem_rd_i == bus.id_rt_i) && (bus.id_rt_i != 5'd0);

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        compare_op   = 3'd0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        pc_src       = 1'b0;
        if_id_flush  = 1'b0;
        inc_branch   = 1'b0;
        inc_taken    = 1'b0;
        inc_stall    = 1'b0;

        if (bus.ext_flush_i) begin
            state_d      = RESOLVE;
            id_ex_bubble = 1'b1;
        end else begin
            case (state_q)
                RESOLVE: begin
                    if (is_branch && stall_need != 2'd0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        inc_stall    = 1'b1;
                        state_d      = (stall_need == 2'd2) ? STALL2 : RESOLVE;
                    end else if (is_branch) begin
                        compare_op  = bus.id_branch_op_i;
                        pc_src      = bus.id_compare_i;
                        if_id_flush = bus.id_compare_i;
                        inc_branch  = 1'b1;
                        inc_taken   = bus.id_compare_i;
                    end
                end
                STALL2: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    inc_stall    = 1'b1;
                    state_d      = RESOLVE;
                end
                default: state_d = RESOLVE;
            endcase
        end
    end

    always_comb begin
        branch_cnt_d = sat_inc(branch_cnt_q, inc_branch);
        taken_cnt_d  = sat_inc(taken_cnt_q, inc_taken);
        stall_cnt_d  = sat_inc(stall_cnt_q, inc_stall);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESOLVE;
            branch_cnt_q <= 16'd0;
            taken_cnt_q  <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.compare_op_o   = compare_op;
    assign bus.pc_write_o     = pc_write;
    assign bus.if_id_write_o  = if_id_write;
    assign bus.id_ex_bubble_o = id_ex_bubble;
    assign bus.pc_src_o       = pc_src;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.branch_count_o = branch_cnt_q;
    assign bus.taken_count_o  = taken_cnt_q;
    assign bus.stall_count_o  = stall_cnt_q;
endmodule
